// File: rtl/press_pkg.sv
// press_pkg: state and event encodings shared by press_classifier and its bench.
package press_pkg;
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PRESS1    = 3'd1,
    WAIT2     = 3'd2,
    PRESS2    = 3'd3,
    LONG_HELD = 3'd4
  } state_t;
  typedef enum logic [1:0] {
    EV_NONE   = 2'd0,
    EV_SHORT  = 2'd1,
    EV_LONG   = 2'd2,
    EV_DOUBLE = 2'd3
  } ev_t;
endpackage

// File: rtl/press_classifier_edge_detect.sv
// edge_detect: registers db (reset to 1 so a held button gives no rise) and flags its edges.
module edge_detect (
  input  logic clk,
  input  logic reset_n,
  input  logic db,
  output logic rise,
  output logic fall
);
  logic db_d;
  always_ff @(posedge clk) db_d <= reset_n ? db : 1'b1;
  assign rise = db & ~db_d;
  assign fall = ~db & db_d;
endmodule

// File: rtl/press_classifier.sv
// press_classifier: classifies debounced presses as short/long/double with an event counter.
// Define PRESS_CNT_SAT_EN to make event_count saturate instead of wrapping.
module press_classifier
  import press_pkg::*;
#(
  parameter int LONG_TICKS = 100,
  parameter int DBL_TICKS  = 30,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             db,
  input  logic             tick,
  output logic             short_press,
  output logic             long_press,
  output logic             double_press,
  output logic [CNT_W-1:0] event_count
);
  localparam int TMAX = LONG_TICKS > DBL_TICKS ? LONG_TICKS : DBL_TICKS;
  localparam int TW = $clog2(TMAX);
  localparam logic [TW-1:0] LONG_LAST = TW'(LONG_TICKS - 1);
  localparam logic [TW-1:0] DBL_LAST  = TW'(DBL_TICKS - 1);
  state_t state, nxt;
  ev_t ev, ev_n;
  logic [TW-1:0] tcnt;
  logic [CNT_W-1:0] cnt_n;
  logic rise, fall, long_end, dbl_end;
  edge_detect u_edge (
    .clk(clk),
    .reset_n(reset_n),
    .db(db),
    .rise(rise),
    .fall(fall)
  );
  assign long_end = tick && tcnt == LONG_LAST;
  assign dbl_end  = tick && tcnt == DBL_LAST;
  // edges are tested before tick terms so an edge always wins a same-cycle tick
  always_comb begin
    nxt  = state;
    ev_n = EV_NONE;
    case (state)
      IDLE:      if (rise) nxt = PRESS1;
      PRESS1:
        if (fall) nxt = WAIT2;
        else if (long_end) begin
          nxt  = LONG_HELD;
          ev_n = EV_LONG;
        end
      WAIT2:
        if (rise) nxt = PRESS2;
        else if (dbl_end) begin
          nxt  = IDLE;
          ev_n = EV_SHORT;
        end
      PRESS2:
        if (fall) begin
          nxt  = IDLE;
          ev_n = EV_DOUBLE;
        end else if (long_end) begin
          nxt  = LONG_HELD;
          ev_n = EV_DOUBLE;
        end
      LONG_HELD: if (fall) nxt = IDLE;
      default:   nxt = IDLE;
    endcase
  end
`ifdef PRESS_CNT_SAT_EN
  assign cnt_n = (ev_n != EV_NONE && ~&event_count) ? event_count + CNT_W'(1) : event_count;
`else
  assign cnt_n = event_count + CNT_W'(ev_n != EV_NONE);
`endif
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      tcnt        <= '0;
      ev          <= EV_NONE;
      event_count <= '0;
    end else begin
      state       <= nxt;
      tcnt        <= nxt != state ? '0 : tcnt + TW'(tick);
      ev          <= ev_n;
      event_count <= cnt_n;
    end
  end
  assign short_press  = ev == EV_SHORT;
  assign long_press   = ev == EV_LONG;
  assign double_press = ev == EV_DOUBLE;
endmodule

// File: tb/tb_press_classifier.sv
// tb_press_classifier: scoreboard bench for press_classifier (LONG=8, DBL=4, CNT_W=4).
module tb_press_classifier;
  import press_pkg::*;
  typedef struct {
    ev_t        ev;
    logic [3:0] cnt;
    int         cyc;
  } exp_t;
  logic clk, reset_n, db, tick;
  logic short_press, long_press, double_press;
  logic [3:0] event_count;
  int checks, failures, cyc;
  exp_t sb[$];
  exp_t e;
  ev_t got;
  press_classifier #(.LONG_TICKS(8), .DBL_TICKS(4), .CNT_W(4)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .db(db),
    .tick(tick),
    .short_press(short_press),
    .long_press(long_press),
    .double_press(double_press),
    .event_count(event_count)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask
  // monitor: every pulse must match the head of the scoreboard
  always @(negedge clk)
    if (short_press | long_press | double_press) begin
      got = short_press ? EV_SHORT : long_press ? EV_LONG : EV_DOUBLE;
      chk("one_hot", $countones({short_press, long_press, double_press}), 1);
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_pulse got=%s want=none at cyc=%0d", got.name(), cyc);
      end else begin
        e = sb.pop_front();
        chk("pulse_kind", int'(got), int'(e.ev));
        chk("pulse_count", int'(event_count), int'(e.cnt));
        chk("pulse_cycle", cyc, e.cyc);
      end
    end
  // n ticks, 10 clk apart; optionally expect a pulse right after the last one
  task automatic ticks(input int n, input ev_t ev = EV_NONE, input int cnt = 0);
    for (int i = 0; i < n; i++) begin
      repeat (9) @(negedge clk);
      tick = 1;
      if (i == n - 1 && ev != EV_NONE) sb.push_back('{ev, 4'(cnt), cyc + 1});
      @(negedge clk);
      tick = 0;
    end
  endtask
  task automatic do_reset(input logic hold);
    reset_n = 0;
    db = hold;
    repeat (3) @(negedge clk);
    chk("reset_outputs", int'({short_press, long_press, double_press, event_count}), 0);
    reset_n = 1;
    @(negedge clk);
  endtask
  task automatic settle(input string name, input int cnt);
    repeat (15) @(negedge clk);
    chk({name, "_sb_empty"}, sb.size(), 0);
    chk({name, "_count"}, int'(event_count), cnt);
  endtask
  task automatic short_gesture(input int cnt);
    db = 1;
    ticks(1);
    db = 0;
    ticks(4, EV_SHORT, cnt);
  endtask
  initial begin
    checks = 0; failures = 0; cyc = 0; tick = 0; db = 0; reset_n = 0;
    do_reset(0);
    db = 1;
    ticks(3);
    db = 0;
    ticks(4, EV_SHORT, 1);
    settle("short", 1);
    do_reset(0);
    db = 1;
    ticks(8, EV_LONG, 1);
    ticks(2);
    db = 0;
    settle("long", 1);
    do_reset(0);
    db = 1;
    ticks(2);
    db = 0;
    ticks(2);
    db = 1;
    ticks(2);
    db = 0;
    sb.push_back('{EV_DOUBLE, 4'd1, cyc + 1});
    ticks(6);
    settle("double", 1);
    do_reset(0);
    db = 1;
    ticks(2);
    db = 0;
    ticks(1);
    db = 1;
    ticks(8, EV_DOUBLE, 1);
    ticks(1);
    db = 0;
    settle("double_hold", 1);
    do_reset(1);
    ticks(2);
    db = 0;
    ticks(6);
    settle("held_at_reset", 0);
    short_gesture(1);
    db = 1;
    ticks(1);
    db = 0;
    ticks(2);
    reset_n = 0;
    @(negedge clk);
    chk("mid_reset_outputs", int'({short_press, long_press, double_press, event_count}), 0);
    reset_n = 1;
    ticks(6);
    settle("mid_reset", 0);
    do_reset(0);
    for (int i = 1; i <= 17; i++)
`ifdef PRESS_CNT_SAT_EN
      short_gesture(i > 15 ? 15 : i);
    settle("seventeen", 15);
`else
      short_gesture(i % 16);
    settle("seventeen", 1);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
